// File: rtl/ker_sram_write.sv
// Kernel write stage: drains the kernel stream from the input FIFO during first-load
// and scatters kernels round-robin across NUM_BANK SRAM banks, packed per bank.
module ker_sram_write #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_BANK = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_ker_words,
  input  logic [CNT_W-1:0]    cfg_ker_num,
  input  logic                isif_empty_n,
  input  logic [DATA_W-1:0]   isif_data,
  output logic                isif_read,
  output logic [NUM_BANK-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BANK_W = $clog2(NUM_BANK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                start_ok;
  logic                rd;
  logic [ADDR_W-1:0]   cfg_words_q;
  logic [CNT_W-1:0]    cfg_num_q;
  logic [ADDR_W-1:0]   word_cnt;
  logic [CNT_W-1:0]    ker_cnt;
  logic [ADDR_W-1:0]   base;
  logic                last_taken;
  logic [BANK_W-1:0]   bank;
  logic                word_wrap;
  logic                is_last;

  assign bank      = ker_cnt[BANK_W-1:0];
  assign word_wrap = (word_cnt == cfg_words_q - ADDR_W'(1));
  assign is_last   = word_wrap && (ker_cnt == cfg_num_q - CNT_W'(1));
  assign rd        = isif_empty_n && (state == S_RUN) && !last_taken;
  assign isif_read = rd;

  // Next-state logic; a zero-sized load skips straight to DONE
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = ((cfg_ker_words != '0) && (cfg_ker_num != '0)) ? S_RUN : S_DONE;
        end
      end
      S_RUN:   if (rd && is_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_we     <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      cfg_words_q <= '0;
      cfg_num_q   <= '0;
      word_cnt    <= '0;
      ker_cnt     <= '0;
      base        <= '0;
      last_taken  <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != S_IDLE);
      done    <= (state_next == S_DONE);
      sram_we <= '0;
      if (start_ok) begin
        cfg_words_q <= cfg_ker_words;
        cfg_num_q   <= cfg_ker_num;
        word_cnt    <= '0;
        ker_cnt     <= '0;
        base        <= '0;
        last_taken  <= 1'b0;
      end
      // Accepted word: register the write, then advance word/kernel/base counters
      if (rd) begin
        sram_we    <= NUM_BANK'(1) << bank;
        sram_addr  <= base + word_cnt;
        sram_wdata <= isif_data;
        if (word_wrap) begin
          word_cnt <= '0;
          ker_cnt  <= ker_cnt + CNT_W'(1);
          if (bank == BANK_W'(NUM_BANK - 1)) base <= base + cfg_words_q;
        end else begin
          word_cnt <= word_cnt + ADDR_W'(1);
        end
        if (is_last) last_taken <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ker_sram_write.sv
// Directed bench for ker_sram_write: table of loads checked against a closed-form
// bank/address model, plus reset-mid-load and 4-bit address wrap sequences.
module tb_ker_sram_write;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned NUM_BANK = 8;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned ADDR_WS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start, isif_empty_n, isif_read, busy, done;
  logic [ADDR_W-1:0]   cfg_ker_words, sram_addr;
  logic [CNT_W-1:0]    cfg_ker_num;
  logic [DATA_W-1:0]   isif_data, sram_wdata;
  logic [NUM_BANK-1:0] sram_we;

  logic                start_w, empty_n_w, read_w, busy_w, done_w;
  logic [ADDR_WS-1:0]  words_w, addr_w;
  logic [CNT_W-1:0]    num_w;
  logic [DATA_W-1:0]   data_w, wdata_w;
  logic [NUM_BANK-1:0] we_w;

  ker_sram_write #(.DATA_W(DATA_W), .NUM_BANK(NUM_BANK), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_ker_words(cfg_ker_words),
    .cfg_ker_num(cfg_ker_num), .isif_empty_n(isif_empty_n), .isif_data(isif_data),
    .isif_read(isif_read), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .busy(busy), .done(done));

  ker_sram_write #(.DATA_W(DATA_W), .NUM_BANK(NUM_BANK), .ADDR_W(ADDR_WS), .CNT_W(CNT_W)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .cfg_ker_words(words_w),
    .cfg_ker_num(num_w), .isif_empty_n(empty_n_w), .isif_data(data_w),
    .isif_read(read_w), .sram_we(we_w), .sram_addr(addr_w),
    .sram_wdata(wdata_w), .busy(busy_w), .done(done_w));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int words;
    int num;
    bit rnd;
    int ign_cyc;
    int exp_total;
    int exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // Expected bank/address of the i-th word of a load with w words per kernel
  task automatic model(input int i, input int w, input int aw, output int bk, output int ad);
    int k;
    k  = i / w;
    bk = k % NUM_BANK;
    ad = ((k / NUM_BANK) * w + (i % w)) % (1 << aw);
  endtask

  task automatic run_load(input int words, input int num, input bit rnd, input int ign_cyc,
                          input int exp_total, input int exp_done, input string tag);
    int popped = 0;
    int nwr = 0;
    int last_rd = -1;
    int done_cyc = -1;
    int bk, ad;
    bit prev_rd = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cfg_ker_words = ADDR_W'(words);
    cfg_ker_num = CNT_W'(num);
    isif_empty_n = 1'b1;
    isif_data = pat(0);
    #1 chk({tag, "_rd_idle"}, isif_read, 0);
    for (int cyc = 1; cyc < 1000 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        cfg_ker_words = ADDR_W'(7);
        cfg_ker_num = CNT_W'(1);
      end
      isif_empty_n = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      isif_data = pat(popped);
      #1;
      if (cyc == 1) chk({tag, "_busy_c1"}, busy, 1);
      chk({tag, "_we_iff_rd"}, 64'(sram_we != '0), 64'(prev_rd));
      if (sram_we != '0) begin
        model(nwr, words, ADDR_W, bk, ad);
        chk({tag, "_we"}, sram_we, 64'(1) << bk);
        chk({tag, "_addr"}, sram_addr, ad);
        chk({tag, "_wdata"}, sram_wdata, pat(nwr));
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_rd_in_done"}, isif_read, 0);
        chk({tag, "_done_lat"}, cyc, (exp_total == 0) ? 1 : last_rd + 1);
      end
      if (isif_read) begin
        popped++;
        last_rd = cyc;
      end
      prev_rd = isif_read;
    end
    chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 1);
    chk({tag, "_reads"}, popped, exp_total);
    chk({tag, "_writes"}, nwr, exp_total);
    if (exp_done >= 0) chk({tag, "_done_cyc"}, done_cyc, exp_done);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_rd_after"}, isif_read, 0);
  endtask

  initial begin
    int popped, nwr, bk, ad, done_cyc;
    int exp16[6];
    vecs[0] = '{4, 10, 1'b0, -1, 40, 41};
    vecs[1] = '{4, 10, 1'b1, -1, 40, -1};
    vecs[2] = '{4,  0, 1'b0, -1,  0,  1};
    vecs[3] = '{0,  3, 1'b0, -1,  0,  1};
    vecs[4] = '{4, 10, 1'b0,  5, 40, 41};
    vecs[5] = '{3,  5, 1'b1, -1, 15, -1};
    exp16 = '{12, 13, 14, 15, 0, 1};

    reset = 1'b1; start = 1'b0; cfg_ker_words = '0; cfg_ker_num = '0;
    isif_empty_n = 1'b1; isif_data = '0;
    start_w = 1'b0; words_w = '0; num_w = '0; empty_n_w = 1'b0; data_w = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd", isif_read, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      run_load(vecs[i].words, vecs[i].num, vecs[i].rnd, vecs[i].ign_cyc,
               vecs[i].exp_total, vecs[i].exp_done, $sformatf("v%0d", i));

    // Reset after the 17th word of a 40-word load, then a fresh 2x2 load
    @(negedge clk);
    start = 1'b1; cfg_ker_words = ADDR_W'(4); cfg_ker_num = CNT_W'(10); isif_empty_n = 1'b1;
    popped = 0;
    for (int cyc = 1; cyc < 100 && popped < 17; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      isif_data = pat(popped);
      #1 if (isif_read) popped++;
    end
    chk("mid_popped", popped, 17);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", sram_we, 0);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_wdata", sram_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", isif_read, 0);
    run_load(2, 2, 1'b0, -1, 4, 5, "after_rst");

    // 4-bit address: bank 0 kernels at base 0, 6, 12; kernel 16 wraps to 0..1
    @(negedge clk);
    start_w = 1'b1; words_w = ADDR_WS'(6); num_w = CNT_W'(24); empty_n_w = 1'b1;
    popped = 0; nwr = 0; done_cyc = -1;
    for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start_w = 1'b0;
      data_w = pat(popped);
      #1;
      if (we_w != '0) begin
        model(nwr, 6, ADDR_WS, bk, ad);
        chk("wrap_we", we_w, 64'(1) << bk);
        chk("wrap_addr", addr_w, ad);
        chk("wrap_wdata", wdata_w, pat(nwr));
        if (nwr >= 96 && nwr < 102) begin
          chk("wrap_k16_bank", we_w, 1);
          chk("wrap_k16_addr", addr_w, exp16[nwr - 96]);
        end
        nwr++;
      end
      if (done_w) done_cyc = cyc;
      if (read_w) popped++;
    end
    chk("wrap_writes", nwr, 144);
    chk("wrap_done_cyc", done_cyc, 145);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
